// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory port arbiter and the stall logic.
package mem_arb_pkg;

  // Arbiter state encoding
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_F = 2'd1,
    ARB_BUSY_D = 2'd2,
    ARB_ERR    = 2'd3
  } arb_state_t;

  // Default fairness window: data grants allowed back to back while a fetch waits
  localparam int ARB_FAIRNESS = 4;

  // Default watchdog limit in cycles for one outstanding access
  localparam int ARB_TIMEOUT = 64;

endpackage

// File: rtl/arb_watchdog.sv
// Saturating up-counter with synchronous clear and count enable.
// expired is high while the registered count sits at MAX.
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int MAX = ARB_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  // Clear wins over enable; the count stops at MAX
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en && (count_reg != MAX_C)) begin
      count_next = count_reg + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign expired = (count_reg == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single multi-cycle memory port between instruction fetch and
// the data stage, routes completions back to the owner, drops flushed fetch
// responses and traps a hung memory with a watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int FAIRNESS = ARB_FAIRNESS,
  parameter int TIMEOUT  = ARB_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_flush,
  output logic              fetch_done,
  output logic [DATA_W-1:0] fetch_rdata,
  output logic              fetch_wait,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_done,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_wait,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  arb_state_t        state_reg, state_next;
  logic              drop_reg, drop_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;

  logic grant_d, grant_f;
  logic fair_en, fair_clr, fair_full;
  logic wd_en, wd_clr, wd_expired;

  // Counts data grants that overtook a waiting fetch
  arb_watchdog #(.MAX(FAIRNESS)) u_fair (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (fair_clr),
    .en      (fair_en),
    .expired (fair_full)
  );

  // Counts cycles since the current access was granted
  arb_watchdog #(.MAX(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Arbitration, completion routing and next-state logic
  always_comb begin
    state_next = state_reg;
    drop_next  = drop_reg;
    grant_d    = 1'b0;
    grant_f    = 1'b0;
    fetch_done = 1'b0;
    data_done  = 1'b0;
    err        = 1'b0;

    case (state_reg)
      ARB_IDLE: begin
        // A flush blocks the fetch this cycle, so data may go even when fairness is spent
        if (data_req && (!fetch_req || !fair_full || fetch_flush)) begin
          grant_d    = 1'b1;
          state_next = ARB_BUSY_D;
        end else if (fetch_req && !fetch_flush) begin
          grant_f    = 1'b1;
          state_next = ARB_BUSY_F;
        end
      end
      ARB_BUSY_F: begin
        if (mem_done) begin
          // A flush landing together with the completion still kills it
          fetch_done = !drop_reg && !fetch_flush;
          drop_next  = 1'b0;
          state_next = ARB_IDLE;
        end else if (wd_expired) begin
          err        = 1'b1;
          state_next = ARB_ERR;
        end else if (fetch_flush) begin
          drop_next  = 1'b1;
        end
      end
      ARB_BUSY_D: begin
        if (mem_done) begin
          data_done  = 1'b1;
          state_next = ARB_IDLE;
        end else if (wd_expired) begin
          err        = 1'b1;
          state_next = ARB_ERR;
        end
      end
      ARB_ERR: begin
        err = 1'b1;
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase

    // Memory strobe and operand mux; the address and write data hold between grants
    mem_en     = grant_d || grant_f;
    mem_wr     = grant_d && data_wr;
    addr_next  = grant_d ? data_addr : (grant_f ? fetch_addr : addr_reg);
    wdata_next = grant_d ? data_wdata : wdata_reg;
    mem_addr   = addr_next;
    mem_wdata  = wdata_next;

    // Read data is only presented alongside its done pulse
    fetch_rdata = fetch_done ? mem_rdata : '0;
    data_rdata  = data_done ? mem_rdata : '0;
    fetch_wait  = fetch_req && !fetch_done;
    data_wait   = data_req && !data_done;

    fair_en  = grant_d && fetch_req;
    fair_clr = grant_f || ((state_reg == ARB_IDLE) && !fetch_req);
    wd_clr   = (state_next == ARB_IDLE);
    wd_en    = (state_next == ARB_BUSY_F) || (state_next == ARB_BUSY_D);
  end

  // State, drop flag and held memory operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ARB_IDLE;
      drop_reg  <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      drop_reg  <= drop_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_mem_port_arbiter;

  localparam int FAIR = 4;
  localparam int TO   = 64;

  logic        clk, rst_n;
  logic        fetch_req, fetch_flush, fetch_done, fetch_wait;
  logic [15:0] fetch_addr, fetch_rdata;
  logic        data_req, data_wr, data_done, data_wait;
  logic [15:0] data_addr, data_wdata, data_rdata;
  logic        mem_en, mem_wr, mem_done, err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .FAIRNESS(FAIR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
    .fetch_done(fetch_done), .fetch_rdata(fetch_rdata), .fetch_wait(fetch_wait),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_done(data_done), .data_rdata(data_rdata), .data_wait(data_wait),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .err(err)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fr, ff, dr, dw;
    logic [15:0] fa, da, dwd, rd;
    logic        en, wr;
    logic [15:0] addr, wdata;
    logic        fd, dd;
  } vec_t;

  vec_t vecs[7];

  task automatic chk1(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", n, a, e, $time);
    end
  endtask

  task automatic chk16(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    fetch_req = 0; fetch_flush = 0; fetch_addr = 0;
    data_req = 0; data_wr = 0; data_addr = 0; data_wdata = 0;
    mem_done = 0; mem_rdata = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, ".mem_en"}, mem_en, 1'b0);
    chk1({tag, ".mem_wr"}, mem_wr, 1'b0);
    chk16({tag, ".mem_addr"}, mem_addr, 16'h0);
    chk16({tag, ".mem_wdata"}, mem_wdata, 16'h0);
    chk1({tag, ".fetch_done"}, fetch_done, 1'b0);
    chk1({tag, ".data_done"}, data_done, 1'b0);
    chk16({tag, ".fetch_rdata"}, fetch_rdata, 16'h0);
    chk16({tag, ".data_rdata"}, data_rdata, 16'h0);
    chk1({tag, ".fetch_wait"}, fetch_wait, 1'b0);
    chk1({tag, ".data_wait"}, data_wait, 1'b0);
    chk1({tag, ".err"}, err, 1'b0);
  endtask

  task automatic run_table();
    vec_t v;
    vecs[0] = '{1, 0, 0, 0, 16'h0040, 16'h0000, 16'h0000, 16'hC123, 1, 0, 16'h0040, 16'h0000, 1, 0};
    vecs[1] = '{0, 0, 1, 0, 16'h0000, 16'h1234, 16'h7777, 16'h5A5A, 1, 0, 16'h1234, 16'h7777, 0, 1};
    vecs[2] = '{1, 0, 1, 1, 16'h0010, 16'h2000, 16'hBEEF, 16'h0000, 1, 1, 16'h2000, 16'hBEEF, 0, 1};
    vecs[3] = '{1, 1, 0, 0, 16'h0050, 16'h0000, 16'h0000, 16'h1357, 0, 0, 16'h2000, 16'hBEEF, 0, 0};
    vecs[4] = '{1, 1, 1, 1, 16'h0060, 16'h3000, 16'h1111, 16'h2468, 1, 1, 16'h3000, 16'h1111, 0, 1};
    vecs[5] = '{0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h9999, 0, 0, 16'h3000, 16'h1111, 0, 0};
    vecs[6] = '{1, 0, 0, 0, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 1, 0, 16'hFFFF, 16'h1111, 1, 0};
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      fetch_req = v.fr; fetch_flush = v.ff; fetch_addr = v.fa;
      data_req = v.dr; data_wr = v.dw; data_addr = v.da; data_wdata = v.dwd;
      mem_done = 0;
      settle();
      chk1($sformatf("vec%0d.mem_en", i), mem_en, v.en);
      chk1($sformatf("vec%0d.mem_wr", i), mem_wr, v.wr);
      chk16($sformatf("vec%0d.mem_addr", i), mem_addr, v.addr);
      chk16($sformatf("vec%0d.mem_wdata", i), mem_wdata, v.wdata);
      chk1($sformatf("vec%0d.fetch_wait", i), fetch_wait, v.fr);
      chk1($sformatf("vec%0d.data_wait", i), data_wait, v.dr);
      cyc();
      // Completion cycle: only the owner keeps its request up
      fetch_req = v.fd; data_req = v.dd; fetch_flush = 0;
      mem_done = 1; mem_rdata = v.rd;
      settle();
      chk1($sformatf("vec%0d.fetch_done", i), fetch_done, v.fd);
      chk1($sformatf("vec%0d.data_done", i), data_done, v.dd);
      chk16($sformatf("vec%0d.fetch_rdata", i), fetch_rdata, v.fd ? v.rd : 16'h0);
      chk16($sformatf("vec%0d.data_rdata", i), data_rdata, v.dd ? v.rd : 16'h0);
      chk1($sformatf("vec%0d.busy_no_en", i), mem_en, 1'b0);
      $display("vec %0d: en=%b addr=%h fd=%b dd=%b", i, v.en, v.addr, v.fd, v.dd);
      cyc();
      idle_inputs();
      cyc();
    end
  endtask

  task automatic run_latency();
    // Fetch alone, memory latency 3
    fetch_req = 1; fetch_addr = 16'h0040;
    settle();
    chk1("lat.mem_en", mem_en, 1'b1);
    chk16("lat.mem_addr", mem_addr, 16'h0040);
    chk1("lat.mem_wr", mem_wr, 1'b0);
    cyc();
    for (int k = 1; k < 3; k++) begin
      settle();
      chk1("lat.fetch_done_early", fetch_done, 1'b0);
      chk1("lat.fetch_wait", fetch_wait, 1'b1);
      chk1("lat.mem_en_busy", mem_en, 1'b0);
      cyc();
    end
    mem_done = 1; mem_rdata = 16'hC123;
    settle();
    chk1("lat.fetch_done", fetch_done, 1'b1);
    chk16("lat.fetch_rdata", fetch_rdata, 16'hC123);
    chk1("lat.fetch_wait_done", fetch_wait, 1'b0);
    $display("fetch latency 3: done=%b rdata=%h", fetch_done, fetch_rdata);
    cyc();
    idle_inputs();
    cyc();

    // Simultaneous fetch and store: data first, fetch right after data_done
    fetch_req = 1; fetch_addr = 16'h0010;
    data_req = 1; data_wr = 1; data_addr = 16'h2000; data_wdata = 16'hBEEF;
    settle();
    chk1("sim.mem_en", mem_en, 1'b1);
    chk1("sim.mem_wr", mem_wr, 1'b1);
    chk16("sim.mem_addr", mem_addr, 16'h2000);
    chk16("sim.mem_wdata", mem_wdata, 16'hBEEF);
    cyc();
    settle();
    chk1("sim.busy_en", mem_en, 1'b0);
    chk1("sim.fetch_wait", fetch_wait, 1'b1);
    cyc();
    mem_done = 1;
    settle();
    chk1("sim.data_done", data_done, 1'b1);
    chk1("sim.fetch_done", fetch_done, 1'b0);
    cyc();
    data_req = 0; mem_done = 0;
    settle();
    chk1("sim.fetch_grant", mem_en, 1'b1);
    chk16("sim.fetch_addr", mem_addr, 16'h0010);
    chk1("sim.fetch_wr", mem_wr, 1'b0);
    cyc();
    mem_done = 1; mem_rdata = 16'hABCD;
    settle();
    chk1("sim.fetch_done2", fetch_done, 1'b1);
    chk16("sim.fetch_rdata", fetch_rdata, 16'hABCD);
    $display("simultaneous: store then fetch rdata=%h", fetch_rdata);
    cyc();
    idle_inputs();
    cyc();
  endtask

  task automatic run_starve();
    logic [15:0] grants[$];
    logic [15:0] exp_g[6];
    logic        pending, drop_f;
    exp_g = '{16'h2222, 16'h2222, 16'h2222, 16'h2222, 16'h0010, 16'h2222};
    pending = 0; drop_f = 0;
    fetch_req = 1; fetch_addr = 16'h0010;
    data_req = 1; data_wr = 0; data_addr = 16'h2222;
    for (int c = 0; c < 40 && grants.size() < 6; c++) begin
      mem_done = pending;
      if (drop_f) fetch_req = 0;
      settle();
      if (mem_en) grants.push_back(mem_addr);
      pending = mem_en;
      drop_f = fetch_done;
      cyc();
    end
    chk16("starve.grant_count", 16'(grants.size()), 16'd6);
    for (int i = 0; i < 6; i++) begin
      chk16($sformatf("starve.grant%0d", i), (i < grants.size()) ? grants[i] : 16'hXXXX, exp_g[i]);
    end
    $display("starvation: %0d grants observed", grants.size());
    fetch_req = 0; data_req = 0; mem_done = 1;
    cyc();
    idle_inputs();
    cyc();
  endtask

  task automatic run_flush();
    fetch_req = 1; fetch_addr = 16'h0080;
    settle();
    chk1("flush.grant", mem_en, 1'b1);
    cyc();
    fetch_flush = 1;
    settle();
    chk1("flush.no_done_pulse", fetch_done, 1'b0);
    cyc();
    fetch_flush = 0; fetch_req = 0;
    cyc();
    mem_done = 1; mem_rdata = 16'hDEAD;
    settle();
    chk1("flush.dropped", fetch_done, 1'b0);
    chk16("flush.rdata", fetch_rdata, 16'h0);
    cyc();
    mem_done = 0; fetch_req = 1; fetch_addr = 16'h0100;
    settle();
    chk1("flush.next_grant", mem_en, 1'b1);
    chk16("flush.next_addr", mem_addr, 16'h0100);
    cyc();
    mem_done = 1; mem_rdata = 16'h4321;
    settle();
    chk1("flush.next_done", fetch_done, 1'b1);
    chk16("flush.next_rdata", fetch_rdata, 16'h4321);
    $display("flush: dropped response, next fetch rdata=%h", fetch_rdata);
    cyc();
    // Flush landing in the same cycle as mem_done
    mem_done = 0; fetch_addr = 16'h0200;
    settle();
    chk1("flush_same.grant", mem_en, 1'b1);
    cyc();
    mem_done = 1; fetch_flush = 1;
    settle();
    chk1("flush_same.dropped", fetch_done, 1'b0);
    cyc();
    idle_inputs();
    cyc();
    fetch_req = 1; fetch_addr = 16'h0300;
    settle();
    chk1("flush_same.next_grant", mem_en, 1'b1);
    cyc();
    mem_done = 1; mem_rdata = 16'h0F0F;
    settle();
    chk1("flush_same.next_done", fetch_done, 1'b1);
    $display("flush same cycle: following fetch done=%b", fetch_done);
    cyc();
    idle_inputs();
    cyc();
  endtask

  task automatic run_timeout();
    data_req = 1; data_wr = 0; data_addr = 16'h4000;
    settle();
    chk1("to.grant", mem_en, 1'b1);
    cyc();
    for (int k = 1; k < TO; k++) begin
      settle();
      chk1($sformatf("to.err_low_%0d", k), err, 1'b0);
      cyc();
    end
    settle();
    chk1("to.err_rise", err, 1'b1);
    chk1("to.no_done", data_done, 1'b0);
    cyc();
    data_req = 0; fetch_req = 1; fetch_addr = 16'h0500;
    for (int k = 0; k < 3; k++) begin
      mem_done = (k == 1);
      settle();
      chk1("to.err_sticky", err, 1'b1);
      chk1("to.no_grant", mem_en, 1'b0);
      chk1("to.fetch_wait", fetch_wait, 1'b1);
      chk1("to.fetch_done", fetch_done, 1'b0);
      chk1("to.data_done", data_done, 1'b0);
      cyc();
    end
    $display("timeout: err=%b after %0d cycles", err, TO);
    // Asynchronous reset between clock edges
    settle();
    #1;
    idle_inputs();
    rst_n = 0;
    #1;
    check_all_zero("to.async_rst");
    cyc();
    rst_n = 1;
    cyc();
  endtask

  task automatic run_random();
    int          owner, fair, mem_left;
    logic        drop, f_clr, d_clr, gd, gf, e_fd, e_dd;
    logic [15:0] last_addr, last_wdata, e_addr, e_wdata;
    owner = 0; fair = 0; mem_left = 0; drop = 0; f_clr = 0; d_clr = 0;
    last_addr = 0; last_wdata = 0;
    for (int c = 0; c < 3000; c++) begin
      if (f_clr) fetch_req = 0;
      if (d_clr) data_req = 0;
      if (!fetch_req && $urandom_range(0, 2) == 0) begin
        fetch_req = 1; fetch_addr = 16'($urandom);
      end
      if (!data_req && $urandom_range(0, 2) == 0) begin
        data_req = 1; data_wr = 1'($urandom_range(0, 1));
        data_addr = 16'($urandom); data_wdata = 16'($urandom);
      end
      fetch_flush = ($urandom_range(0, 7) == 0);
      mem_rdata = 16'($urandom);
      if (mem_left > 0) begin
        mem_left--;
        mem_done = (mem_left == 0);
      end else begin
        mem_done = ($urandom_range(0, 15) == 0);
      end
      settle();
      gd = (owner == 0) && data_req && (!fetch_req || fair < FAIR || fetch_flush);
      gf = (owner == 0) && !gd && fetch_req && !fetch_flush;
      e_addr  = gd ? data_addr : (gf ? fetch_addr : last_addr);
      e_wdata = gd ? data_wdata : last_wdata;
      e_fd = (owner == 1) && mem_done && !drop && !fetch_flush;
      e_dd = (owner == 2) && mem_done;
      chk1("rnd.mem_en", mem_en, gd || gf);
      chk1("rnd.mem_wr", mem_wr, gd && data_wr);
      chk16("rnd.mem_addr", mem_addr, e_addr);
      chk16("rnd.mem_wdata", mem_wdata, e_wdata);
      chk1("rnd.fetch_done", fetch_done, e_fd);
      chk1("rnd.data_done", data_done, e_dd);
      chk16("rnd.fetch_rdata", fetch_rdata, e_fd ? mem_rdata : 16'h0);
      chk16("rnd.data_rdata", data_rdata, e_dd ? mem_rdata : 16'h0);
      chk1("rnd.fetch_wait", fetch_wait, fetch_req && !e_fd);
      chk1("rnd.data_wait", data_wait, data_req && !e_dd);
      chk1("rnd.err", err, 1'b0);
      if (owner == 0) begin
        if (!fetch_req || gf) fair = 0;
        else if (gd && fair < FAIR) fair++;
        last_addr = e_addr;
        last_wdata = e_wdata;
        if (gd) owner = 2;
        else if (gf) owner = 1;
        if (gd || gf) mem_left = $urandom_range(1, 4);
      end else if (owner == 1) begin
        if (mem_done) begin
          owner = 0; drop = 0;
        end else if (fetch_flush) begin
          drop = 1;
        end
      end else if (mem_done) begin
        owner = 0;
      end
      f_clr = e_fd || fetch_flush;
      d_clr = e_dd;
      cyc();
    end
    $display("random: 3000 cycles, errors so far=%0d", errors);
    idle_inputs();
    cyc();
  endtask

  // Main sequence
  initial begin
    rst_n = 0;
    idle_inputs();
    #12;
    check_all_zero("reset");
    $display("reset: outputs checked");
    cyc();
    rst_n = 1;
    cyc();
    run_table();
    run_latency();
    run_starve();
    run_flush();
    run_timeout();
    run_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Time limit so a stuck run still ends with a verdict
  initial begin
    #2000000;
    errors++;
    $display("FAIL time_limit: simulation did not complete, got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single multi-cycle unified memory port between the fetch stage (read-only instruction requests) and the memory stage (data loads and stores).
It arbitrates between the two, tracks the in-flight access, and routes the completion pulse and read data back to the owning requester.
It drops a fetch response killed by a branch/jump flush, and traps a hung memory with a watchdog.
Its *_wait outputs feed the pipeline hazard/stall logic.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data word width
FAIRNESS, 4, max consecutive data grants while a fetch is pending before fetch is forced to win
TIMEOUT, 64, max cycles an access may stay outstanding before a fatal error

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
fetch_req  in  1  fetch request, level, held until fetch_done or flushed
fetch_addr  in  ADDR_W  fetch address
fetch_flush  in  1  one-cycle pulse: discard the current fetch request/response
fetch_done  out  1  one-cycle pulse: fetch_rdata valid
fetch_rdata  out  DATA_W  instruction word
fetch_wait  out  1  fetch_req high and fetch_done low this cycle
data_req  in  1  data request, level, held until data_done
data_wr  in  1  1 = store, 0 = load
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  store data
data_done  out  1  one-cycle pulse: access complete, data_rdata valid on loads
data_rdata  out  DATA_W  load data
data_wait  out  1  data_req high and data_done low this cycle
mem_en  out  1  one-cycle access strobe to memory
mem_wr  out  1  write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_done  in  1  memory completion pulse, at least 1 cycle after mem_en
mem_rdata  in  DATA_W  memory read data, valid with mem_done
err  out  1  sticky watchdog error

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; fairness count = 0; watchdog = 0; drop flag = 0.
  - All outputs are 0.
- States:
  - IDLE: no access in flight.
  - BUSY_F: fetch access in flight.
  - BUSY_D: data access in flight.
  - ERR: terminal.
- IDLE arbitration, combinational, same cycle:
  - If data_req is high and (fetch_req is low, or fairness count < FAIRNESS, or fetch_flush is high): grant data.
  - Otherwise, if fetch_req is high and fetch_flush is low: grant fetch.
  - On a grant: mem_en = 1 for that cycle, with mem_addr, mem_wr and mem_wdata muxed from the winner (fetch grant drives mem_wr = 0). The next state is BUSY_D or BUSY_F.
  - If neither is granted, mem_en = 0 and mem_addr/mem_wdata hold their last granted values.
- Fairness count:
  - Increments on a data grant while fetch_req is high, saturating at FAIRNESS.
  - Clears on any fetch grant, or in IDLE when fetch_req is low.
- BUSY_x:
  - mem_en = 0.
  - On mem_done: pulse the owner's *_done that same cycle, with rdata passed through combinationally from mem_rdata, then return to IDLE.
  - Minimum request-to-done latency is 1 cycle; peak throughput is 1 access per 2 cycles.
- Flush:
  - fetch_flush in BUSY_F sets the drop flag.
  - At mem_done with the drop flag set, fetch_done stays 0, the drop flag clears, and the state returns to IDLE.
  - fetch_flush in any other state is a no-op apart from blocking a fetch grant that cycle.
  - A flush in the same cycle as mem_done still drops the response.
- Watchdog:
  - Counts cycles in BUSY_x and clears on entry to IDLE.
  - If it reaches TIMEOUT with no mem_done, the block enters ERR.
  - In ERR: err = 1, no further grants, no done pulses, *_wait follow their requests. Only reset leaves ERR.
- Robustness:
  - mem_done while in IDLE or ERR is ignored.
  - A request dropped before being granted leaves no state behind.
  - Reset mid-access abandons it silently and produces no done pulse.
- Width: all address/data paths are pass-through with no arithmetic. The watchdog counter is clog2(TIMEOUT+1) bits and the fairness counter is clog2(FAIRNESS+1) bits.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state encoding localparams ARB_IDLE, ARB_BUSY_F, ARB_BUSY_D, ARB_ERR;
  - the default FAIRNESS and TIMEOUT constants, shared with the stall logic.
- One sub-module, arb_watchdog: a saturating cycle counter with clear/enable inputs and an expired output, reused for the fairness counter as a second instance.

Test Plan:
- Fetch only: fetch_addr = 0x0040, memory latency 3 -> mem_en for 1 cycle with mem_addr = 0x0040, mem_wr = 0; fetch_done 3 cycles later with fetch_rdata = 0xC123; fetch_wait high until then.
- Simultaneous requests, fetch 0x0010 and store 0x2000 = 0xBEEF -> data granted first (mem_wr = 1, mem_wdata = 0xBEEF); fetch issued in the cycle after data_done.
- Starvation: data_req held continuously with fetch_req high, FAIRNESS = 4 -> exactly 4 data grants, then a fetch grant, then data resumes.
- Flush: fetch in flight, fetch_flush pulse, mem_done 2 cycles later -> no fetch_done pulse; a new fetch to 0x0100 the next cycle is granted normally.
- Timeout: data load issued, mem_done never arrives, TIMEOUT = 64 -> err rises 64 cycles after the grant and stays high; a later fetch_req gets no mem_en; rst_n low clears err and all outputs asynchronously.
- Spurious mem_done in IDLE -> no done pulses and no state change.
